// File: rtl/forwarding_unit_if.sv
// Decode/execute-side signal bundle of the operand forwarding unit.
// master = pipeline side (decode/execute/mem/wb), slave = forwarding unit.
interface forwarding_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [DATA_W-1:0]     mem_alu_res;
  logic [DATA_W-1:0]     wb_data;
  logic                  stall;
  logic                  fw_data_1_valid;
  logic [DATA_W-1:0]     fw_data_1;
  logic                  fw_data_2_valid;
  logic [DATA_W-1:0]     fw_data_2;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
           mem_alu_res, wb_data,
    input  stall, fw_data_1_valid, fw_data_1, fw_data_2_valid, fw_data_2
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
           mem_alu_res, wb_data,
    output stall, fw_data_1_valid, fw_data_1, fw_data_2_valid, fw_data_2
  );
endinterface

// File: rtl/forwarding_unit.sv
// Execute-stage operand forwarding with load-use stall detection.
// Optional FW_PERF_CNT_EN adds stall_cnt / fwd_cnt performance counters.
module forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FW_PERF_CNT_EN
  output logic [31:0]        stall_cnt,
  output logic [31:0]        fwd_cnt,
`endif
  forwarding_unit_if.slave   bus
);

  typedef enum logic [1:0] {SEL_NONE, SEL_MEM, SEL_WB} sel_e;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } ex_ent_t;

  ex_ent_t               ex_q, ex_d;
  logic                  mem_vld_q, mem_we_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  sel_e                  sel1_q, sel1_d, sel2_q, sel2_d;
  logic                  hz, stall;

  // Youngest producer first: the execute entry will sit in MEM when the
  // consumer reaches execute, the memory entry will sit in WB.
  function automatic sel_e pick(input logic [REG_ADDR_W-1:0] rs, input ex_ent_t ex,
                                input logic mv, input logic [REG_ADDR_W-1:0] mrd,
                                input logic mwe);
    pick = SEL_NONE;
    if (rs != '0) begin
      if (ex.vld && ex.we && !ex.ld && ex.rd == rs) pick = SEL_MEM;
      else if (mv && mwe && mrd == rs)              pick = SEL_WB;
    end
  endfunction

  function automatic logic [DATA_W-1:0] fw_mux(input sel_e s, input logic [DATA_W-1:0] m,
                                               input logic [DATA_W-1:0] w);
    case (s)
      SEL_MEM: fw_mux = m;
      SEL_WB:  fw_mux = w;
      default: fw_mux = '0;
    endcase
  endfunction

  assign hz = bus.id_valid && ex_q.vld && ex_q.we && ex_q.ld && (ex_q.rd != '0) &&
              ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));
  // A flushed consumer never executes, so it must not hold the front end.
  assign stall     = hz && !bus.flush;
  assign bus.stall = stall;

  always_comb begin
    ex_d   = '0;
    sel1_d = SEL_NONE;
    sel2_d = SEL_NONE;
    if (bus.id_valid && !bus.flush && !stall) begin
      ex_d.vld = 1'b1;
      ex_d.rd  = bus.id_rd;
      ex_d.we  = bus.id_reg_write;
      ex_d.ld  = bus.id_mem_read;
      sel1_d   = pick(bus.id_rs1, ex_q, mem_vld_q, mem_rd_q, mem_we_q);
      sel2_d   = pick(bus.id_rs2, ex_q, mem_vld_q, mem_rd_q, mem_we_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_vld_q <= 1'b0;
      mem_rd_q  <= '0;
      mem_we_q  <= 1'b0;
      sel1_q    <= SEL_NONE;
      sel2_q    <= SEL_NONE;
    end else begin
      ex_q      <= ex_d;
      mem_vld_q <= ex_q.vld;
      mem_rd_q  <= ex_q.rd;
      mem_we_q  <= ex_q.we;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
    end
  end

  assign bus.fw_data_1_valid = (sel1_q != SEL_NONE);
  assign bus.fw_data_2_valid = (sel2_q != SEL_NONE);
  assign bus.fw_data_1       = fw_mux(sel1_q, bus.mem_alu_res, bus.wb_data);
  assign bus.fw_data_2       = fw_mux(sel2_q, bus.mem_alu_res, bus.wb_data);

`ifdef FW_PERF_CNT_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall};
      fwd_cnt_q   <= fwd_cnt_q + {31'd0, bus.fw_data_1_valid | bus.fw_data_2_valid};
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Cycle-table bench for forwarding_unit with an expected-result scoreboard.
module tb_forwarding_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forwarding_unit_if #(.REG_ADDR_W(5), .DATA_W(32)) bus ();

`ifdef FW_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
  forwarding_unit #(.REG_ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt), .bus(bus));
`else
  forwarding_unit #(.REG_ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    logic        rst, vld;
    logic [4:0]  rs1, rs2, rd;
    logic        we, ld, fl;
    logic [31:0] mres, wbd;
    logic        e_st, e_v1;
    logic [31:0] e_d1;
    logic        e_v2;
    logic [31:0] e_d2;
  } vec_t;

  typedef struct {
    int          idx;
    logic        st, v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic ld,
                              input logic fl, input logic [31:0] mres, input logic [31:0] wbd,
                              input logic st, input logic v1, input logic [31:0] d1,
                              input logic v2, input logic [31:0] d2);
    vec_t v;
    v.rst = 1'b0; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.we = we; v.ld = ld; v.fl = fl; v.mres = mres; v.wbd = wbd;
    v.e_st = st; v.e_v1 = v1; v.e_d1 = d1; v.e_v2 = v2; v.e_d2 = d2;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of decode/bus inputs, then check the outputs mid-cycle.
  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = v.rst;
    bus.id_valid     = v.vld;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rd        = v.rd;
    bus.id_reg_write = v.we;
    bus.id_mem_read  = v.ld;
    bus.flush        = v.fl;
    bus.mem_alu_res  = v.mres;
    bus.wb_data      = v.wbd;
    sb.push_back('{n_step, v.e_st, v.e_v1, v.e_d1, v.e_v2, v.e_d2});
    n_step++;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty step %0d: got 0 entries expected 1", n_step);
    end else begin
      e = sb.pop_front();
      chk("stall",           e.idx, {31'd0, bus.stall},           {31'd0, e.st});
      chk("fw_data_1_valid", e.idx, {31'd0, bus.fw_data_1_valid}, {31'd0, e.v1});
      chk("fw_data_1",       e.idx, bus.fw_data_1,                e.d1);
      chk("fw_data_2_valid", e.idx, {31'd0, bus.fw_data_2_valid}, {31'd0, e.v2});
      chk("fw_data_2",       e.idx, bus.fw_data_2,                e.d2);
    end
  endtask

  task automatic idle(input logic r, input logic [31:0] m, input logic [31:0] w,
                      input logic v1, input logic [31:0] d1);
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, m, w, 0, v1, d1, 0, 0);
    v.rst = r;
    step(v);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.flush = 0;
    bus.mem_alu_res = 0; bus.wb_data = 0;
    repeat (2) @(posedge clk);

    //                 vld rs1 rs2 rd we ld fl  mem_alu_res   wb_data     st v1 d1          v2 d2
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h1111, 32'h2222, 0, 0, 0,          0, 0));
    // ALU producer x5 then consumer rs1=5 -> MEM forward
    tbl.push_back(mk(1, 0, 0, 5,  1, 0, 0, 32'h1111, 32'h2222, 0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 5, 6, 8,  1, 0, 0, 32'h1234, 32'h9999, 0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h1234, 32'h5555, 0, 1, 32'h1234,   0, 0));
    // x5 in both ex and mem, consumer rs2=5 -> youngest (MEM) wins
    tbl.push_back(mk(1, 0, 0, 5,  1, 0, 0, 32'hA,    32'hB,    0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 0, 0, 5,  1, 0, 0, 32'hA,    32'hB,    0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 0, 5, 9,  1, 0, 0, 32'hA,    32'hB,    0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'hA,    32'hB,    0, 0, 0,          1, 32'hA));
    // rs1==rs2 matching the mem entry -> both forwarded from WB
    tbl.push_back(mk(1, 9, 9, 0,  0, 0, 0, 32'h77,   32'h88,   0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h77,   32'h88,   0, 1, 32'h88,     1, 32'h88));
    // load-use: one stall, then WB forward of the load result
    tbl.push_back(mk(1, 0, 0, 7,  1, 1, 0, 32'h3,    32'h4,    0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 7, 0, 10, 1, 0, 0, 32'h3,    32'h4,    1, 0, 0,          0, 0));
    tbl.push_back(mk(1, 7, 0, 10, 1, 0, 0, 32'h3,    32'h4,    0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h3,    32'hCAFE, 0, 1, 32'hCAFE,   0, 0));
    // load-use coinciding with flush -> no stall, no forward
    tbl.push_back(mk(1, 0, 0, 7,  1, 1, 0, 32'h5,    32'h6,    0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 7, 7, 1,  1, 0, 1, 32'h5,    32'h6,    0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h5,    32'h6,    0, 0, 0,          0, 0));
    // rd=0 producer, we=0 producers, rs=0 consumers -> never forwarded
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 0, 0, 3,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 0, 3, 0,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 3, 3, 0,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    // invalid decode slot carrying rd=4 is not a producer
    tbl.push_back(mk(0, 0, 0, 4,  1, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(1, 4, 4, 0,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    // load in ex with invalid decode slot -> no stall
    tbl.push_back(mk(1, 0, 0, 6,  1, 1, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 6, 0,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 32'h44,   32'h55,   0, 0, 0,          0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset asserted during a stall clears ex/mem: the held consumer sees no producer.
    step(mk(1, 0, 0, 7, 1, 1, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0));
    v = mk(1, 7, 0, 2, 1, 0, 0, 32'h1, 32'h2, 1, 0, 0, 0, 0);
    v.rst = 1'b1;
    step(v);
    step(mk(1, 7, 0, 2, 1, 0, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0));
    idle(0, 32'h1, 32'h2, 0, 0);

`ifdef FW_PERF_CNT_EN
    idle(1, 32'h1, 32'h2, 0, 0);
    step(mk(1, 0, 0, 7, 1, 1, 0, 32'h1, 32'h2,  0, 0, 0,      0, 0));
    step(mk(1, 7, 0, 2, 1, 0, 0, 32'h1, 32'h2,  1, 0, 0,      0, 0));
    step(mk(1, 7, 0, 2, 1, 0, 0, 32'h1, 32'h2,  0, 0, 0,      0, 0));
    step(mk(1, 0, 0, 7, 1, 1, 0, 32'h1, 32'hD1, 0, 1, 32'hD1, 0, 0));
    step(mk(1, 7, 0, 2, 1, 0, 0, 32'h1, 32'h2,  1, 0, 0,      0, 0));
    step(mk(1, 7, 0, 2, 1, 0, 0, 32'h1, 32'h2,  0, 0, 0,      0, 0));
    step(mk(1, 0, 0, 5, 1, 0, 0, 32'h1, 32'hD2, 0, 1, 32'hD2, 0, 0));
    step(mk(1, 5, 0, 0, 0, 0, 0, 32'h1, 32'h2,  0, 0, 0,      0, 0));
    idle(0, 32'hE3, 32'h2, 1, 32'hE3);
    idle(0, 32'h1, 32'h2, 0, 0);
    chk("stall_cnt", n_step, stall_cnt, 32'd2);
    chk("fwd_cnt",   n_step, fwd_cnt,   32'd3);
    idle(1, 32'h1, 32'h2, 0, 0);
    idle(0, 32'h1, 32'h2, 0, 0);
    chk("stall_cnt_rst", n_step, stall_cnt, 32'd0);
    chk("fwd_cnt_rst",   n_step, fwd_cnt,   32'd0);
`endif

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
